// File: rtl/eth_rx_framer_if.sv
// rtl/eth_rx_framer_if.sv - SRAM strobe bus and CPU frame handshake for eth_rx_framer.
// Optional ETH_RX_CRC_EN adds crc_ok.
interface eth_rx_framer_if #(
   parameter int ADDR_W = 10
) ();
   logic [7:0]      d;
   logic [ADDR_W:0] a;
   logic            n_we;
   logic            n_cs;
   logic            frame_ready;
   logic            frame_bank;
   logic [ADDR_W:0] frame_len;
   logic            frame_ack;
   logic [7:0]      overrun_cnt;
`ifdef ETH_RX_CRC_EN
   logic            crc_ok;
`endif

   modport master (
      output d, a, n_we, n_cs, frame_ready, frame_bank, frame_len, overrun_cnt,
`ifdef ETH_RX_CRC_EN
      output crc_ok,
`endif
      input  frame_ack
   );

   modport slave (
      input  d, a, n_we, n_cs, frame_ready, frame_bank, frame_len, overrun_cnt,
`ifdef ETH_RX_CRC_EN
      input  crc_ok,
`endif
      output frame_ack
   );
endinterface

// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - oversampled sck/sda receiver writing frames into ping-pong SRAM banks.
// Optional ETH_RX_CRC_EN: per-bank CRC-32 check reported on crc_ok.
module eth_rx_framer #(
   parameter int ADDR_W      = 10,
   parameter int IDLE_CYCLES = 64,
   parameter int WE_CYCLES   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic sda,
   eth_rx_framer_if.master bus
);
   typedef enum logic [1:0] {WR_IDLE, WR_LOW, WR_HOLD} wr_state_t;

   logic            r_sck_s1, r_sck_s2, r_sck_d;
   logic            r_sda_s1, r_sda_s2;
   logic [1:0]      r_arm_cnt;
   logic            r_in_frame;
   logic            r_drop;
   logic [15:0]     r_idle_cnt;
   logic [2:0]      r_bit_cnt;
   logic [6:0]      r_shift;
   logic [ADDR_W:0] r_bytes;
   logic            r_wb, r_rb;
   logic [1:0]      r_ready;
   logic [ADDR_W:0] r_len [2];
   logic [7:0]      r_overrun;

   wr_state_t       r_state;
   logic [2:0]      r_we_cnt;
   logic [7:0]      r_d;
   logic [ADDR_W:0] r_a;
   logic            r_n_we, r_n_cs;

   logic            w_edge, w_drop, w_byte_done, w_full, w_wr_start;
   logic            w_frame_end, w_deliver, w_ack;
   logic [1:0]      w_ready_next;

   // Edges are ignored until the synchroniser has flushed post-reset values.
   assign w_edge      = (r_arm_cnt == 2'd3) & r_sck_s2 & ~r_sck_d;
   assign w_drop      = r_in_frame ? r_drop : r_ready[r_wb];
   assign w_byte_done = w_edge & (r_bit_cnt == 3'd7);
   assign w_full      = r_bytes[ADDR_W];
   assign w_wr_start  = w_byte_done & ~w_drop & ~w_full;
   assign w_frame_end = r_in_frame & ~w_edge & (r_idle_cnt == 16'(IDLE_CYCLES - 1));
   assign w_deliver   = w_frame_end & ~r_drop & (r_bytes != '0);
   assign w_ack       = bus.frame_ack & r_ready[r_rb];

   always_comb begin
      w_ready_next = r_ready;
      if (w_ack)
         w_ready_next[r_rb] = 1'b0;
      if (w_deliver)
         w_ready_next[r_wb] = 1'b1;
   end

`ifdef ETH_RX_CRC_EN
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   logic [31:0] r_crc_run, r_crc_byte;
   logic [1:0]  r_crc_ok;
   logic        r_trunc;
   logic [31:0] w_crc_in, w_crc_next;

   assign w_crc_in   = r_in_frame ? r_crc_run : 32'hFFFFFFFF;
   assign w_crc_next = {1'b0, w_crc_in[31:1]} ^
                       ((w_crc_in[0] ^ r_sda_s2) ? CRC_POLY : 32'h0);

   // r_crc_byte only advances on whole bytes so a trailing partial byte never counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc_run  <= '0;
         r_crc_byte <= '0;
         r_crc_ok   <= '0;
         r_trunc    <= 1'b0;
      end else begin
         if (w_edge) begin
            r_crc_run <= w_crc_next;
            if (!r_in_frame)
               r_trunc <= 1'b0;
            if (w_byte_done && !w_full)
               r_crc_byte <= w_crc_next;
            if (w_byte_done && w_full)
               r_trunc <= 1'b1;
         end
         if (w_deliver)
            r_crc_ok[r_wb] <= (r_crc_byte == CRC_RESIDUE) &&
                              (r_bytes > (ADDR_W + 1)'(3)) && !r_trunc;
      end
   end

   assign bus.crc_ok = r_crc_ok[r_rb];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sck_s1   <= 1'b0;
         r_sck_s2   <= 1'b0;
         r_sck_d    <= 1'b0;
         r_sda_s1   <= 1'b0;
         r_sda_s2   <= 1'b0;
         r_arm_cnt  <= '0;
         r_in_frame <= 1'b0;
         r_drop     <= 1'b0;
         r_idle_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_bytes    <= '0;
         r_wb       <= 1'b0;
         r_rb       <= 1'b0;
         r_ready    <= '0;
         r_len[0]   <= '0;
         r_len[1]   <= '0;
         r_overrun  <= '0;
      end else begin
         r_sck_s1 <= sck;
         r_sck_s2 <= r_sck_s1;
         r_sck_d  <= r_sck_s2;
         r_sda_s1 <= sda;
         r_sda_s2 <= r_sda_s1;
         if (r_arm_cnt != 2'd3)
            r_arm_cnt <= r_arm_cnt + 2'd1;

         if (w_edge) begin
            r_idle_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_shift    <= {r_sda_s2, r_shift[6:1]};
            if (!r_in_frame) begin
               r_in_frame <= 1'b1;
               r_drop     <= r_ready[r_wb];
               r_bytes    <= '0;
            end else if (w_byte_done && !r_drop && !w_full) begin
               r_bytes <= r_bytes + (ADDR_W + 1)'(1);
            end
         end else if (r_in_frame) begin
            if (w_frame_end) begin
               r_in_frame <= 1'b0;
               r_bit_cnt  <= '0;
               r_idle_cnt <= '0;
               if (r_drop && r_overrun != 8'hFF)
                  r_overrun <= r_overrun + 8'd1;
            end else begin
               r_idle_cnt <= r_idle_cnt + 16'd1;
            end
         end

         r_ready <= w_ready_next;
         if (w_ack)
            r_rb <= ~r_rb;
         if (w_deliver) begin
            r_len[r_wb] <= r_bytes;
            r_wb        <= ~r_wb;
         end
      end
   end

   // SRAM write strobe sequencer: WE_CYCLES low, one hold cycle, then release.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= WR_IDLE;
         r_we_cnt <= '0;
         r_d      <= '0;
         r_a      <= '0;
         r_n_we   <= 1'b1;
         r_n_cs   <= 1'b1;
      end else begin
         case (r_state)
            WR_IDLE: begin
               if (w_wr_start) begin
                  r_d      <= {r_sda_s2, r_shift};
                  r_a      <= {r_wb, r_bytes[ADDR_W-1:0]};
                  r_n_we   <= 1'b0;
                  r_n_cs   <= 1'b0;
                  r_we_cnt <= '0;
                  r_state  <= WR_LOW;
               end
            end
            WR_LOW: begin
               if (r_we_cnt == 3'(WE_CYCLES - 1)) begin
                  r_n_we  <= 1'b1;
                  r_state <= WR_HOLD;
               end else begin
                  r_we_cnt <= r_we_cnt + 3'd1;
               end
            end
            WR_HOLD: begin
               r_n_cs  <= 1'b1;
               r_state <= WR_IDLE;
            end
            default: begin
               r_n_we  <= 1'b1;
               r_n_cs  <= 1'b1;
               r_state <= WR_IDLE;
            end
         endcase
      end
   end

   assign bus.d           = r_d;
   assign bus.a           = r_a;
   assign bus.n_we        = r_n_we;
   assign bus.n_cs        = r_n_cs;
   assign bus.frame_ready = r_ready[r_rb];
   assign bus.frame_bank  = r_rb;
   assign bus.frame_len   = r_len[r_rb];
   assign bus.overrun_cnt = r_overrun;
endmodule

// File: tb/tb_eth_rx_framer.sv
// tb/tb_eth_rx_framer.sv - scoreboard bench for eth_rx_framer (ADDR_W=10 and ADDR_W=4 instances).
// Define ETH_RX_CRC_EN to include the CRC scenario.
module tb_eth_rx_framer;
   localparam int IDLE = 64;
   localparam int WE   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sck = 1'b0;
   logic sda = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon0 = 1'b1;
   bit   mon4 = 1'b0;

   eth_rx_framer_if #(.ADDR_W(10)) if0 ();
   eth_rx_framer_if #(.ADDR_W(4))  if4 ();

   eth_rx_framer #(.ADDR_W(10), .IDLE_CYCLES(IDLE), .WE_CYCLES(WE)) dut (
      .clk(clk), .rst(rst), .sck(sck), .sda(sda), .bus(if0.master));
   eth_rx_framer #(.ADDR_W(4), .IDLE_CYCLES(IDLE), .WE_CYCLES(WE)) dut4 (
      .clk(clk), .rst(rst), .sck(sck), .sda(sda), .bus(if4.master));

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         sb0[$];
   wr_t         sb4[$];
   wr_t         e0, e4;
   int          low0 = 0, low4 = 0;
   logic [10:0] ca0, ca4;
   logic [7:0]  cd0, cd4;

   // Write monitors: capture each n_we pulse and compare against the scoreboard.
   always @(negedge clk) begin
      if (!mon0 || rst) begin
         low0 = 0;
      end else if (!if0.n_we) begin
         if (low0 == 0) begin
            ca0 = if0.a;
            cd0 = if0.d;
         end
         low0++;
      end else if (low0 != 0) begin
         n_vec++;
         if (sb0.size() == 0) begin
            n_err++;
            $display("FAIL wr0_unexpected got a=%h d=%h required no write", ca0, cd0);
         end else begin
            e0 = sb0.pop_front();
            if ({ca0, cd0} !== {e0.a, e0.d}) begin
               n_err++;
               $display("FAIL wr0_data got a=%h d=%h required a=%h d=%h", ca0, cd0, e0.a, e0.d);
            end
         end
         n_vec++;
         if (low0 != WE || if0.n_cs !== 1'b0) begin
            n_err++;
            $display("FAIL wr0_strobe got low=%0d cs_hold=%b required low=%0d cs_hold=0", low0, if0.n_cs, WE);
         end
         low0 = 0;
      end
   end

   always @(negedge clk) begin
      if (!mon4 || rst) begin
         low4 = 0;
      end else if (!if4.n_we) begin
         if (low4 == 0) begin
            ca4 = 11'(if4.a);
            cd4 = if4.d;
         end
         low4++;
      end else if (low4 != 0) begin
         n_vec++;
         if (sb4.size() == 0) begin
            n_err++;
            $display("FAIL wr4_unexpected got a=%h d=%h required no write", ca4, cd4);
         end else begin
            e4 = sb4.pop_front();
            if ({ca4, cd4} !== {e4.a, e4.d}) begin
               n_err++;
               $display("FAIL wr4_data got a=%h d=%h required a=%h d=%h", ca4, cd4, e4.a, e4.d);
            end
         end
         low4 = 0;
      end
   end

   task automatic send_bit(input logic b);
      sda = b;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         send_bit(v[i]);
   endtask

   task automatic exp0(input logic [10:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb0.push_back(e);
   endtask

   task automatic exp4(input logic [10:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb4.push_back(e);
   endtask

   task automatic idle();
      repeat (IDLE + 20) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sck = 1'b0;
      if0.frame_ack = 1'b0;
      if4.frame_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      sb0.delete();
      sb4.delete();
   endtask

   task automatic ack0();
      if0.frame_ack = 1'b1;
      @(negedge clk);
      if0.frame_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sck = 1'b1;
      if0.frame_ack = 1'b0;
      if4.frame_ack = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++;
      if ({if0.n_we, if0.n_cs} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_strobes got %b required 11", {if0.n_we, if0.n_cs});
      end
      n_vec++;
      if ({if0.d, if0.a} !== 19'h0) begin
         n_err++;
         $display("FAIL reset_bus got d=%h a=%h required 0", if0.d, if0.a);
      end
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len, if0.overrun_cnt} !== 21'h0) begin
         n_err++;
         $display("FAIL reset_cpu got rdy=%b bank=%b len=%0d ovr=%0d required 0", if0.frame_ready, if0.frame_bank, if0.frame_len, if0.overrun_cnt);
      end
`ifdef ETH_RX_CRC_EN
      n_vec++;
      if (if0.crc_ok !== 1'b0) begin
         n_err++;
         $display("FAIL reset_crc got %b required 0", if0.crc_ok);
      end
`endif
      rst = 1'b0;
      repeat (10) @(negedge clk);
      sck = 1'b0;
      idle();
      n_vec++;
      if (if0.frame_ready !== 1'b0 || sb0.size() != 0) begin
         n_err++;
         $display("FAIL reset_sck_high got rdy=%b required 0", if0.frame_ready);
      end
   endtask

   task automatic test_single();
      logic [7:0] f [7];
      f = '{8'h10, 8'hd5, 8'h20, 8'hff, 8'h00, 8'ha5, 8'h73};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         exp0(11'(i), f[i]);
         send_byte(f[i]);
      end
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len} !== {1'b1, 1'b0, 11'd7}) begin
         n_err++;
         $display("FAIL single_frame got rdy=%b bank=%b len=%0d required 1 0 7", if0.frame_ready, if0.frame_bank, if0.frame_len);
      end
      n_vec++;
      if (sb0.size() != 0) begin
         n_err++;
         $display("FAIL single_missing got %0d pending writes required 0", sb0.size());
      end
      ack0();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank} !== 2'b01) begin
         n_err++;
         $display("FAIL single_ack got rdy=%b bank=%b required 0 1", if0.frame_ready, if0.frame_bank);
      end
   endtask

   task automatic test_pingpong();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp0(11'(i), 8'(8'h41 + i));
         send_byte(8'(8'h41 + i));
      end
      idle();
      for (int i = 0; i < 5; i++) begin
         exp0(11'(11'h400 + i), 8'(8'hb0 + 3 * i));
         send_byte(8'(8'hb0 + 3 * i));
      end
      idle();
      for (int i = 0; i < 4; i++)
         send_byte(8'(8'he0 + i));
      idle();
      n_vec++;
      if (if0.overrun_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL pp_overrun got %0d required 1", if0.overrun_cnt);
      end
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len} !== {1'b1, 1'b0, 11'd3}) begin
         n_err++;
         $display("FAIL pp_first got rdy=%b bank=%b len=%0d required 1 0 3", if0.frame_ready, if0.frame_bank, if0.frame_len);
      end
      ack0();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len} !== {1'b1, 1'b1, 11'd5}) begin
         n_err++;
         $display("FAIL pp_second got rdy=%b bank=%b len=%0d required 1 1 5", if0.frame_ready, if0.frame_bank, if0.frame_len);
      end
      ack0();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank} !== 2'b00) begin
         n_err++;
         $display("FAIL pp_empty got rdy=%b bank=%b required 0 0", if0.frame_ready, if0.frame_bank);
      end
      ack0();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank} !== 2'b00) begin
         n_err++;
         $display("FAIL pp_stray_ack got rdy=%b bank=%b required 0 0", if0.frame_ready, if0.frame_bank);
      end
      n_vec++;
      if (sb0.size() != 0) begin
         n_err++;
         $display("FAIL pp_missing got %0d pending writes required 0", sb0.size());
      end
   endtask

   task automatic test_partial();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp0(11'(i), 8'(8'h5c ^ i));
         send_byte(8'(8'h5c ^ i));
      end
      for (int i = 0; i < 5; i++)
         send_bit(1'(i));
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_len} !== {1'b1, 11'd3} || sb0.size() != 0) begin
         n_err++;
         $display("FAIL partial_len got rdy=%b len=%0d pending=%0d required 1 3 0", if0.frame_ready, if0.frame_len, sb0.size());
      end
   endtask

   task automatic test_bank_full();
      do_reset();
      mon0 = 1'b0;
      mon4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 16)
            exp4(11'(i), 8'(i * 7 + 3));
         send_byte(8'(i * 7 + 3));
      end
      idle();
      n_vec++;
      if ({if4.frame_ready, if4.frame_bank, if4.frame_len} !== {1'b1, 1'b0, 5'd16}) begin
         n_err++;
         $display("FAIL full_len got rdy=%b bank=%b len=%0d required 1 0 16", if4.frame_ready, if4.frame_bank, if4.frame_len);
      end
      n_vec++;
      if (sb4.size() != 0) begin
         n_err++;
         $display("FAIL full_missing got %0d pending writes required 0", sb4.size());
      end
`ifdef ETH_RX_CRC_EN
      n_vec++;
      if (if4.crc_ok !== 1'b0) begin
         n_err++;
         $display("FAIL full_crc got %b required 0", if4.crc_ok);
      end
`endif
      mon4 = 1'b0;
      mon0 = 1'b1;
   endtask

   task automatic test_reset_mid();
      int  t;
      do_reset();
      exp0(11'd0, 8'h9e);
      send_byte(8'h9e);
      exp0(11'd1, 8'h27);
      send_byte(8'h27);
      for (int i = 0; i < 4; i++)
         send_bit(1'b1);
      sda = 1'b0;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({if0.n_we, if0.n_cs, if0.frame_ready} !== 3'b110) begin
         n_err++;
         $display("FAIL rst_bit_strobes got we=%b cs=%b rdy=%b required 1 1 0", if0.n_we, if0.n_cs, if0.frame_ready);
      end
      repeat (2) @(negedge clk);
      sck = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      exp0(11'd0, 8'h3c);
      send_byte(8'h3c);
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_len} !== {1'b1, 11'd1} || sb0.size() != 0) begin
         n_err++;
         $display("FAIL rst_bit_realign got rdy=%b len=%0d pending=%0d required 1 1 0", if0.frame_ready, if0.frame_len, sb0.size());
      end
      for (int i = 0; i < 7; i++)
         send_bit(1'(8'h5a >> i));
      sda = 1'b0;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      t = 0;
      while (if0.n_we !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_vec++;
      if (if0.n_we !== 1'b0) begin
         n_err++;
         $display("FAIL rst_we_wait got n_we=%b after %0d clk required 0", if0.n_we, t);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({if0.n_we, if0.n_cs, if0.frame_ready} !== 3'b110) begin
         n_err++;
         $display("FAIL rst_we_strobes got we=%b cs=%b rdy=%b required 1 1 0", if0.n_we, if0.n_cs, if0.frame_ready);
      end
      repeat (2) @(negedge clk);
      sck = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      exp0(11'd0, 8'h81);
      send_byte(8'h81);
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len} !== {1'b1, 1'b0, 11'd1} || sb0.size() != 0) begin
         n_err++;
         $display("FAIL rst_we_realign got rdy=%b bank=%b len=%0d pending=%0d required 1 0 1 0", if0.frame_ready, if0.frame_bank, if0.frame_len, sb0.size());
      end
   endtask

`ifdef ETH_RX_CRC_EN
   task automatic test_crc();
      logic [7:0] m [13];
      m = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hf4, 8'hcb};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         exp0(11'(i), m[i]);
         send_byte(m[i]);
      end
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_len, if0.crc_ok} !== {1'b1, 11'd13, 1'b1}) begin
         n_err++;
         $display("FAIL crc_good got rdy=%b len=%0d ok=%b required 1 13 1", if0.frame_ready, if0.frame_len, if0.crc_ok);
      end
      ack0();
      m[0] = 8'h30;
      for (int i = 0; i < 13; i++) begin
         exp0(11'(11'h400 + i), m[i]);
         send_byte(m[i]);
      end
      idle();
      n_vec++;
      if ({if0.frame_ready, if0.frame_bank, if0.frame_len, if0.crc_ok} !== {1'b1, 1'b1, 11'd13, 1'b0}) begin
         n_err++;
         $display("FAIL crc_bad got rdy=%b bank=%b len=%0d ok=%b required 1 1 13 0", if0.frame_ready, if0.frame_bank, if0.frame_len, if0.crc_ok);
      end
   endtask
`endif

   initial begin
      if0.frame_ack = 1'b0;
      if4.frame_ack = 1'b0;
      test_reset();
      test_single();
      test_pingpong();
      test_partial();
      test_bank_full();
      test_reset_mid();
`ifdef ETH_RX_CRC_EN
      test_crc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
